// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its downstream execution unit.
package instr_register_pkg;

    localparam int DEPTH = 32;

    typedef enum logic [2:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  index_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        EXEC,
        OUTPUT,
        DONE
    } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU: executes one instruction on 64-bit sign-extended operands.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr_i,
    output result_t      result_o,
    output logic         div_err_o
);

    result_t a;
    result_t b;

    assign a = {{32{instr_i.op_a[31]}}, instr_i.op_a};
    assign b = {{32{instr_i.op_b[31]}}, instr_i.op_b};

    // Opcode decode; division by zero yields 0 and raises div_err.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result_o  = '0;
        div_err_o = 1'b0;
        case (instr_i.opc)
            ZERO:  result_o = '0;
            PASSA: result_o = a;
            PASSB: result_o = b;
            ADD:   result_o = a + b;
            SUB:   result_o = a - b;
            MULT:  result_o = a * b;
            DIV: begin
                if (b == '0) div_err_o = 1'b1;
                else         result_o  = a / b;
            end
            MOD: begin
                if (b == '0) div_err_o = 1'b1;
                else         result_o  = a % b;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Walks a (possibly wrapping) range of register entries, executes each one and
// hands the results to a sink over a valid/ready handshake.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter bit HALT_ON_ERR = 1'b0,
    parameter int DEPTH       = instr_register_pkg::DEPTH
) (
    input  logic         clk,
    input  logic         reset_en,
    input  logic         start,
    input  index_t       first_index,
    input  index_t       last_index,
    output index_t       read_index,
    input  instruction_t instruction,
    output logic         res_valid,
    input  logic         res_ready,
    output result_t      result,
    output index_t       res_index,
    output opcode_t      res_opcode,
    output logic         div_err,
    output logic         busy,
    output logic         done
);

    localparam index_t WRAP_IDX = index_t'(DEPTH - 1);

    exec_state_t  state_q, state_d;
    index_t       cur_q, cur_d;
    index_t       last_q, last_d;
    index_t       read_index_q, read_index_d;
    instruction_t instr_q, instr_d;
    result_t      result_q, result_d;
    index_t       res_index_q, res_index_d;
    opcode_t      res_opcode_q, res_opcode_d;
    logic         div_err_q, div_err_d;
    logic         res_valid_q, res_valid_d;

    result_t      alu_result;
    logic         alu_div_err;

    instr_alu u_alu (
        .instr_i   (instr_q),
        .result_o  (alu_result),
        .div_err_o (alu_div_err)
    );

    // State and output registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset_en) begin
        if (reset_en) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            read_index_q <= '0;
            // NOTE: the captured instruction is a plain register, so it is reset like the rest.
            instr_q      <= '0;
            result_q     <= '0;
            res_index_q  <= '0;
            res_opcode_q <= ZERO;
            div_err_q    <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            read_index_q <= read_index_d;
            instr_q      <= instr_d;
            result_q     <= result_d;
            res_index_q  <= res_index_d;
            res_opcode_q <= res_opcode_d;
            div_err_q    <= div_err_d;
            res_valid_q  <= res_valid_d;
        end
    end

    // Next-state logic: fetch, capture, execute, then hold until the sink accepts.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_d       = last_q;
        read_index_d = read_index_q;
        instr_d      = instr_q;
        result_d     = result_q;
        res_index_d  = res_index_q;
        res_opcode_d = res_opcode_q;
        div_err_d    = div_err_q;
        res_valid_d  = res_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = first_index;
                    last_d  = last_index;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                read_index_d = cur_q;
                state_d      = CAPTURE;
            end
            CAPTURE: begin
                instr_d = instruction;
                state_d = EXEC;
            end
            EXEC: begin
                result_d     = alu_result;
                res_index_d  = cur_q;
                res_opcode_d = instr_q.opc;
                div_err_d    = alu_div_err;
                res_valid_d  = 1'b1;
                state_d      = OUTPUT;
            end
            OUTPUT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if ((cur_q == last_q) || (HALT_ON_ERR && div_err_q)) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = (cur_q == WRAP_IDX) ? '0 : cur_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign read_index = read_index_q;
    assign result     = result_q;
    assign res_index  = res_index_q;
    assign res_opcode = res_opcode_q;
    assign div_err    = div_err_q;
    assign res_valid  = res_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule
